// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MULT/DIV sequencer: 32-step shift-add multiply and restoring divide
// on magnitudes, with a final sign-fix step that writes HI/LO.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUCntrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic                 op_div;
    logic                 neg_main;
    logic                 neg_rem;

    logic                 is_mul_code, is_div_code, b_zero, accept;
    logic [WIDTH-1:0]     abs_a, abs_b, addend;
    logic [WIDTH:0]       mul_sum, div_trial;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign is_mul_code = (ALUCntrl == 4'd9);
    assign is_div_code = (ALUCntrl == 4'd14);
    assign b_zero      = (b == '0);
    assign accept      = start && (state == S_IDLE || state == S_DONE)
                         && (is_mul_code || is_div_code);

    assign abs_a = a[WIDTH-1] ? ('0 - a) : a;
    assign abs_b = b[WIDTH-1] ? ('0 - b) : b;

    // acc = {partial product upper half, remaining multiplier bits}
    assign addend  = acc[0] ? opnd : '0;
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    // acc = {partial remainder, dividend bits being shifted out / quotient bits shifted in}
    assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
    assign div_ok    = ~div_trial[WIDTH];

    assign prod_fix = neg_main ? ('0 - acc) : acc;
    assign quo_fix  = neg_main ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    assign rem_fix  = neg_rem ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (is_div_code) state_nx = b_zero ? S_DONE : S_DIV;
                    else             state_nx = S_MUL;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_MUL, S_DIV: if (cnt == CW'(1)) state_nx = S_FIX;
            S_FIX:        state_nx = S_DONE;
            default:      state_nx = S_IDLE;
        endcase
    end

    assign busy = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            op_div      <= 1'b0;
            neg_main    <= 1'b0;
            neg_rem     <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            op_div      <= is_div_code;
            neg_main    <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem     <= a[WIDTH-1];
            opnd        <= is_div_code ? abs_b : abs_a;
            acc         <= {{WIDTH{1'b0}}, (is_div_code ? abs_a : abs_b)};
            cnt         <= CW'(WIDTH);
            div_by_zero <= 1'b0;
            if (is_div_code && b_zero) begin
                hi          <= a;
                lo          <= '1;
                div_by_zero <= 1'b1;
            end
        end else begin
            case (state)
                S_MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt - CW'(1);
                end
                S_DIV: begin
                    acc <= {(div_ok ? div_trial[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1]),
                            acc[WIDTH-2:0], div_ok};
                    cnt <= cnt - CW'(1);
                end
                S_FIX: begin
                    if (op_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
